pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Replaces the hard-tied stall=0 and the missing flush/bypass paths.
- Generates per-stage stall and flush strobes for load-use hazards, taken branches/jumps and multi-cycle data-memory waits.
- Bypasses MEM/WB results into EX operands and keeps saturating stall/flush performance counters.

Parameters:
XLEN, 64, datapath width of operands and PC
REG_AW, 5, register address width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_rs1, id_rs2  in  REG_AW  source registers of instruction in ID
id_rs1_used, id_rs2_used  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  REG_AW  source registers of instruction in EX
ex_rs1_rf, ex_rs2_rf  in  XLEN  register-file values latched into ID/EX
ex_rd  in  REG_AW  EX destination
ex_wr_en, ex_is_load  in  1  EX writes rd / is a load
mem_rd  in  REG_AW  MEM destination
mem_wr_en, mem_is_load  in  1  MEM writes rd / is a load
mem_fwd_data  in  XLEN  ALU result in MEM
wb_rd  in  REG_AW  WB destination
wb_wr_en  in  1  WB write enable
wb_data  in  XLEN  final write-back data
branch_taken  in  1  EX resolved a taken branch/jump
branch_target  in  XLEN  EX redirect target
dm_busy  in  1  data memory not ready this cycle
ex_op1, ex_op2  out  XLEN  forwarded EX operands
fwd_sel1, fwd_sel2  out  2  0=RF, 1=MEM, 2=WB
pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall  out  1  hold stage register
ifid_flush, idex_flush  out  1  load bubble into stage register
redirect_valid  out  1  PC must load redirect_pc
redirect_pc  out  XLEN  redirect target
stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

Behaviour:
- Reset: FSM=RUN, redirect_pending=0, redirect_pc_q=0, stall_cnt=0, flush_cnt=0. All stall/flush/redirect outputs 0 while rst is high. Reset mid-wait discards any pending redirect.
- FSM states RUN and MEM_WAIT. RUN->MEM_WAIT when dm_busy=1. MEM_WAIT->RUN on the first cycle with dm_busy=0.
- Priority in RUN, highest first: dm_busy, then branch, then load-use.
- dm_busy=1 (either state): all five stall outputs=1, both flushes=0, redirect_valid=0, stall_cnt+1.
- In MEM_WAIT, branch_taken=1 sets redirect_pending and latches redirect_pc_q=branch_target, once only. Repeat assertions while pending are ignored.
- First cycle with dm_busy=0 and redirect_pending=1:
  - redirect_valid=1, redirect_pc=redirect_pc_q.
  - ifid_flush=idex_flush=1.
  - pending cleared, flush_cnt+1.
  - Live branch_taken in that cycle is the same branch and is ignored.
- RUN with branch_taken=1: redirect_valid=1, redirect_pc=branch_target (combinational, same cycle), ifid_flush=idex_flush=1, flush_cnt+1. Any load-use hazard in that cycle is suppressed.
- Load-use hazard: ex_is_load & ex_wr_en & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Response: pc_stall=ifid_stall=1, idex_flush=1, stall_cnt+1.
  - Exactly one bubble per hazard.
- Forwarding, per operand, rs!=0 required:
  - MEM match with mem_wr_en & !mem_is_load -> sel 1, data mem_fwd_data.
  - Else WB match with wb_wr_en -> sel 2, data wb_data.
  - Else sel 0, data ex_rsN_rf.
  - MEM has priority over WB. x0 is never forwarded.
- Counters saturate at all-ones. Pure combinational outputs have zero latency; counters update on the next rising edge.

Optional Feature:
HAZARD_FWD_EN
- Defined: forwarding exactly as above.
- Undefined: ex_opN=ex_rsN_rf and fwd_selN=0 always.
  - The load-use condition is widened to any RAW match of a used ID source against ex_rd/ex_wr_en, mem_rd/mem_wr_en or wb_rd/wb_wr_en (rd!=0).
  - Stall is held each cycle while a match persists (pc_stall, ifid_stall, idex_flush), so stalls last up to 3 cycles.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5 -> one cycle pc_stall=ifid_stall=idex_flush=1, stall_cnt 0->1; next cycle all stall/flush outputs 0.
- EX rs1=x7, mem_rd=x7, mem_wr_en=1, mem_fwd_data=0x11, wb_rd=x7, wb_data=0x22 -> fwd_sel1=1, ex_op1=0x11. Repeat with rd=x0 -> sel 0, ex_op1=ex_rs1_rf.
- branch_taken=1, target=0x80000040, simultaneous load-use -> redirect_valid=1, redirect_pc=0x80000040, ifid/idex flush=1, pc_stall=0, flush_cnt+1.
- dm_busy high 3 cycles, branch_taken (target 0x1000) asserted throughout -> 3 cycles all stalls=1, no redirect; 4th cycle redirect_valid=1, redirect_pc=0x1000, exactly one flush, stall_cnt+3.
- Assert rst during MEM_WAIT with redirect pending -> all outputs and counters 0 immediately, no redirect after release.
- HAZARD_FWD_EN undefined, ALU writer of x3 in EX, ID reads x3 -> stall held 3 consecutive cycles until WB passes; fwd_sel stays 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV64 pipeline.
// Produces per-stage stall/flush strobes for load-use hazards, taken
// branches and data-memory waits, bypasses MEM/WB results into the EX
// operands, and keeps saturating stall/flush counters.
// Optional feature macro: HAZARD_FWD_EN (defined = MEM/WB bypass enabled;
// undefined = no bypass, any RAW match against EX/MEM/WB stalls ID).
module pipeline_hazard_ctrl #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [XLEN-1:0]   ex_rs1_rf,
  input  logic [XLEN-1:0]   ex_rs2_rf,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr_en,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr_en,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              dm_busy,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              memwb_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic              redirect_pending_q, redirect_pending_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              stall_inc, flush_inc;
  logic              hit_ex, hazard;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // True when a used ID source register matches a non-x0 destination.
  function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic              rs1_used,
                                   input logic [REG_AW-1:0] rs2,
                                   input logic              rs2_used);
    return (rd != '0) && ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  assign hit_ex = src_hit(ex_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used);

`ifdef HAZARD_FWD_EN
  // Operand bypass: an ALU result in MEM wins over WB; x0 is never bypassed.
  always_comb begin
    fwd_sel1 = 2'd0;
    ex_op1   = ex_rs1_rf;
    fwd_sel2 = 2'd0;
    ex_op2   = ex_rs2_rf;
    if ((ex_rs1 != '0) && mem_wr_en && !mem_is_load && (mem_rd == ex_rs1)) begin
      fwd_sel1 = 2'd1;
      ex_op1   = mem_fwd_data;
    end else if ((ex_rs1 != '0) && wb_wr_en && (wb_rd == ex_rs1)) begin
      fwd_sel1 = 2'd2;
      ex_op1   = wb_data;
    end
    if ((ex_rs2 != '0) && mem_wr_en && !mem_is_load && (mem_rd == ex_rs2)) begin
      fwd_sel2 = 2'd1;
      ex_op2   = mem_fwd_data;
    end else if ((ex_rs2 != '0) && wb_wr_en && (wb_rd == ex_rs2)) begin
      fwd_sel2 = 2'd2;
      ex_op2   = wb_data;
    end
  end

  // With bypass only a load in EX cannot feed the next instruction in time.
  assign hazard = ex_is_load && ex_wr_en && hit_ex;
`else
  logic hit_mem, hit_wb;
  logic unused_fwd;

  assign hit_mem  = src_hit(mem_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used);
  assign hit_wb   = src_hit(wb_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used);
  assign ex_op1   = ex_rs1_rf;
  assign ex_op2   = ex_rs2_rf;
  assign fwd_sel1 = 2'd0;
  assign fwd_sel2 = 2'd0;
  // Without bypass ID must wait until every in-flight writer has retired.
  assign hazard   = (ex_wr_en && hit_ex) || (mem_wr_en && hit_mem) || (wb_wr_en && hit_wb);
  assign unused_fwd = ^{mem_fwd_data, wb_data, mem_is_load, ex_rs1, ex_rs2, ex_is_load};
`endif

  // Next-state and strobe generation; priority is memory wait, then redirect, then RAW stall.
  always_comb begin
    state_d            = state_q;
    redirect_pending_d = redirect_pending_q;
    redirect_pc_d      = redirect_pc_q;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;
    pc_stall           = 1'b0;
    ifid_stall         = 1'b0;
    idex_stall         = 1'b0;
    exmem_stall        = 1'b0;
    memwb_stall        = 1'b0;
    ifid_flush         = 1'b0;
    idex_flush         = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    case (state_q)
      RUN: begin
        if (dm_busy) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!dm_busy) begin
          state_d = RUN;
        end else if (branch_taken && !redirect_pending_q) begin
          // Remember the first redirect seen while frozen; later repeats are the same branch.
          redirect_pending_d = 1'b1;
          redirect_pc_d      = branch_target;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst) begin
      if (dm_busy) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_stall = 1'b1;
        stall_inc   = 1'b1;
      end else if (redirect_pending_q) begin
        // Live branch_taken here is the held branch itself, so it is not re-taken.
        redirect_valid     = 1'b1;
        redirect_pc        = redirect_pc_q;
        ifid_flush         = 1'b1;
        idex_flush         = 1'b1;
        redirect_pending_d = 1'b0;
        flush_inc          = 1'b1;
      end else if (branch_taken) begin
        redirect_valid = 1'b1;
        redirect_pc    = branch_target;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
        flush_inc      = 1'b1;
      end else if (hazard) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end
  end

  // State, pending redirect and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= RUN;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= '0;
      stall_cnt_q        <= '0;
      flush_cnt_q        <= '0;
    end else begin
      state_q            <= state_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
      if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand sequences for the
// multi-cycle cases, and random stimulus against a reference model.
module tb_pipeline_hazard_ctrl;
  localparam int XLEN = 64;
  localparam int RA   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [RA-1:0]   id_rs1, id_rs2;
    logic            id_rs1_used, id_rs2_used;
    logic [RA-1:0]   ex_rs1, ex_rs2;
    logic [XLEN-1:0] ex_rs1_rf, ex_rs2_rf;
    logic [RA-1:0]   ex_rd;
    logic            ex_wr_en, ex_is_load;
    logic [RA-1:0]   mem_rd;
    logic            mem_wr_en, mem_is_load;
    logic [XLEN-1:0] mem_fwd_data;
    logic [RA-1:0]   wb_rd;
    logic            wb_wr_en;
    logic [XLEN-1:0] wb_data;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            dm_busy;
  } in_t;

  typedef struct packed {
    logic [XLEN-1:0] op1, op2;
    logic [1:0]      sel1, sel2;
    logic [4:0]      stl;   // {pc, ifid, idex, exmem, memwb}
    logic [1:0]      fl;    // {ifid, idex}
    logic            rv;
    logic [XLEN-1:0] rpc;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  cur;

  logic [XLEN-1:0] ex_op1, ex_op2, redirect_pc;
  logic [1:0]      fwd_sel1, fwd_sel2;
  logic            pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic            ifid_flush, idex_flush, redirect_valid;
  logic [CW-1:0]   stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_pass = 0;

  bit              m_wait, m_pend;
  logic [XLEN-1:0] m_pc;
  int              m_sc, m_fc;

  pipeline_hazard_ctrl #(.XLEN(XLEN), .REG_AW(RA), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
    .id_rs1_used(cur.id_rs1_used), .id_rs2_used(cur.id_rs2_used),
    .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2),
    .ex_rs1_rf(cur.ex_rs1_rf), .ex_rs2_rf(cur.ex_rs2_rf),
    .ex_rd(cur.ex_rd), .ex_wr_en(cur.ex_wr_en), .ex_is_load(cur.ex_is_load),
    .mem_rd(cur.mem_rd), .mem_wr_en(cur.mem_wr_en), .mem_is_load(cur.mem_is_load),
    .mem_fwd_data(cur.mem_fwd_data),
    .wb_rd(cur.wb_rd), .wb_wr_en(cur.wb_wr_en), .wb_data(cur.wb_data),
    .branch_taken(cur.branch_taken), .branch_target(cur.branch_target),
    .dm_busy(cur.dm_busy),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic reads(input in_t i, input logic [RA-1:0] rd);
    return (rd != 0) && ((i.id_rs1_used && i.id_rs1 == rd) || (i.id_rs2_used && i.id_rs2 == rd));
  endfunction

  // Reference: operand source chosen from the youngest non-load producer, then the strobe priority.
  function automatic exp_t model(input in_t i);
    exp_t e;
    logic hz;
    e = '0;
`ifdef HAZARD_FWD_EN
    e.op1 = i.ex_rs1_rf;
    e.op2 = i.ex_rs2_rf;
    if (i.ex_rs1 != 0 && i.mem_wr_en && !i.mem_is_load && i.mem_rd == i.ex_rs1) begin
      e.sel1 = 2'd1; e.op1 = i.mem_fwd_data;
    end else if (i.ex_rs1 != 0 && i.wb_wr_en && i.wb_rd == i.ex_rs1) begin
      e.sel1 = 2'd2; e.op1 = i.wb_data;
    end
    if (i.ex_rs2 != 0 && i.mem_wr_en && !i.mem_is_load && i.mem_rd == i.ex_rs2) begin
      e.sel2 = 2'd1; e.op2 = i.mem_fwd_data;
    end else if (i.ex_rs2 != 0 && i.wb_wr_en && i.wb_rd == i.ex_rs2) begin
      e.sel2 = 2'd2; e.op2 = i.wb_data;
    end
    hz = i.ex_is_load && i.ex_wr_en && reads(i, i.ex_rd);
`else
    e.op1 = i.ex_rs1_rf;
    e.op2 = i.ex_rs2_rf;
    hz = (i.ex_wr_en && reads(i, i.ex_rd)) || (i.mem_wr_en && reads(i, i.mem_rd)) ||
         (i.wb_wr_en && reads(i, i.wb_rd));
`endif
    if (i.dm_busy) e.stl = 5'b11111;
    else if (m_pend) begin e.fl = 2'b11; e.rv = 1'b1; e.rpc = m_pc; end
    else if (i.branch_taken) begin e.fl = 2'b11; e.rv = 1'b1; e.rpc = i.branch_target; end
    else if (hz) begin e.stl = 5'b11000; e.fl = 2'b01; end
    return e;
  endfunction

  function automatic exp_t mk(input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2,
                              input logic [1:0] s1, input logic [1:0] s2, input logic [4:0] stl,
                              input logic [1:0] fl, input logic rv, input logic [XLEN-1:0] rpc);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.sel1 = s1; e.sel2 = s2;
    e.stl = stl; e.fl = fl; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction

  task automatic cmp(input exp_t e, input string t);
    chk({t, ".op1"}, ex_op1, e.op1);
    chk({t, ".op2"}, ex_op2, e.op2);
    chk({t, ".sel"}, 64'({fwd_sel1, fwd_sel2}), 64'({e.sel1, e.sel2}));
    chk({t, ".stall"}, 64'({pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall}), 64'(e.stl));
    chk({t, ".flush"}, 64'({ifid_flush, idex_flush}), 64'(e.fl));
    chk({t, ".rv"}, 64'(redirect_valid), 64'(e.rv));
    chk({t, ".rpc"}, redirect_pc, e.rpc);
  endtask

  // One clock: apply v, check outputs mid-cycle, then advance the model across the edge.
  task automatic run(input in_t v, input string t, input bit has_x, input exp_t x);
    exp_t e;
    cur = v;
    @(negedge clk);
    e = model(v);
    cmp(e, t);
    if (has_x) cmp(x, {t, "/tab"});
    chk({t, ".stall_cnt"}, 64'(stall_cnt), 64'(m_sc));
    chk({t, ".flush_cnt"}, 64'(flush_cnt), 64'(m_fc));
    @(posedge clk);
    if (e.stl[4] && m_sc < CMAX) m_sc++;
    if (e.rv && m_fc < CMAX) m_fc++;
    if (e.rv && m_pend) m_pend = 1'b0;
    else if (m_wait && v.dm_busy && v.branch_taken && !m_pend) begin
      m_pend = 1'b1;
      m_pc = v.branch_target;
    end
    m_wait = v.dm_busy;
    #1;
  endtask

  // Raise reset at the current time (inputs left as they are) and check it acts immediately.
  task automatic do_reset(input string t);
    rst = 1'b1;
    #2;
    chk({t, ".rst_stall"}, 64'({pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall}), 64'(0));
    chk({t, ".rst_flush"}, 64'({ifid_flush, idex_flush, redirect_valid}), 64'(0));
    chk({t, ".rst_cnt"}, 64'({stall_cnt, flush_cnt}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_wait = 1'b0; m_pend = 1'b0; m_pc = '0; m_sc = 0; m_fc = 0;
  endtask

  in_t  idle, v;
  vec_t tab[14];
  exp_t none;

  initial begin
    idle = '0;
    idle.ex_rs1_rf = 64'hA1;
    idle.ex_rs2_rf = 64'hA2;
    cur = idle;
    none = '0;
    do_reset("init");

    for (int k = 0; k < 14; k++) begin
      tab[k].i = idle;
      tab[k].e = mk(64'hA1, 64'hA2, 2'd0, 2'd0, 5'b0, 2'b0, 1'b0, '0);
    end
    tab[1].i.ex_rs1 = 7; tab[1].i.mem_rd = 7; tab[1].i.mem_wr_en = 1; tab[1].i.mem_fwd_data = 64'h11;
    tab[1].i.wb_rd = 7; tab[1].i.wb_wr_en = 1; tab[1].i.wb_data = 64'h22;
    tab[2].i = tab[1].i; tab[2].i.mem_rd = 0; tab[2].i.wb_rd = 0;
    tab[3].i.ex_rs2 = 9; tab[3].i.wb_rd = 9; tab[3].i.wb_wr_en = 1; tab[3].i.wb_data = 64'h22;
    tab[4].i = tab[3].i; tab[4].i.mem_rd = 9; tab[4].i.mem_wr_en = 1; tab[4].i.mem_is_load = 1;
    tab[4].i.mem_fwd_data = 64'h11;
    tab[5].i.ex_rs1 = 7; tab[5].i.ex_rs2 = 7; tab[5].i.mem_rd = 7; tab[5].i.mem_wr_en = 1;
    tab[5].i.mem_fwd_data = 64'h11;
    tab[6].i.ex_rd = 5; tab[6].i.ex_wr_en = 1; tab[6].i.ex_is_load = 1;
    tab[6].i.id_rs1 = 5; tab[6].i.id_rs1_used = 1;
    tab[6].e.stl = 5'b11000; tab[6].e.fl = 2'b01;
    tab[7].i = tab[6].i; tab[7].i.id_rs1_used = 0; tab[7].i.id_rs2 = 5; tab[7].i.id_rs2_used = 1;
    tab[7].e.stl = 5'b11000; tab[7].e.fl = 2'b01;
    tab[8].i = tab[6].i; tab[8].i.id_rs1_used = 0; tab[8].i.id_rs2 = 5;
    tab[9].i = tab[6].i; tab[9].i.ex_rd = 0; tab[9].i.id_rs1 = 0;
    tab[10].i = tab[6].i; tab[10].i.ex_is_load = 0;
    tab[11].i = tab[6].i; tab[11].i.branch_taken = 1; tab[11].i.branch_target = 64'h80000040;
    tab[11].e.fl = 2'b11; tab[11].e.rv = 1; tab[11].e.rpc = 64'h80000040;
    tab[12].i = tab[6].i; tab[12].i.ex_wr_en = 0;
    tab[13].i.wb_rd = 6; tab[13].i.wb_wr_en = 1; tab[13].i.id_rs2 = 6; tab[13].i.id_rs2_used = 1;
`ifdef HAZARD_FWD_EN
    tab[1].e.sel1 = 1; tab[1].e.op1 = 64'h11;
    tab[3].e.sel2 = 2; tab[3].e.op2 = 64'h22;
    tab[4].e.sel2 = 2; tab[4].e.op2 = 64'h22;
    tab[5].e.sel1 = 1; tab[5].e.op1 = 64'h11; tab[5].e.sel2 = 1; tab[5].e.op2 = 64'h11;
`else
    tab[10].e.stl = 5'b11000; tab[10].e.fl = 2'b01;
    tab[13].e.stl = 5'b11000; tab[13].e.fl = 2'b01;
`endif
    for (int k = 0; k < 14; k++) run(tab[k].i, $sformatf("vec%0d", k), 1'b1, tab[k].e);

    // Load-use produces one bubble; the load then moves on to MEM.
    do_reset("lu");
    run(tab[6].i, "lu0", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b11000, 2'b01, 0, '0));
    chk("lu.stall_cnt1", 64'(stall_cnt), 64'(1));
    v = idle; v.id_rs1 = 5; v.id_rs1_used = 1; v.mem_rd = 5; v.mem_wr_en = 1; v.mem_is_load = 1;
`ifdef HAZARD_FWD_EN
    run(v, "lu1", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b0, 2'b0, 0, '0));
`else
    run(v, "lu1", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b11000, 2'b01, 0, '0));
`endif

    // Three busy cycles with the branch held; redirect fires once on release.
    do_reset("mw");
    v = idle; v.dm_busy = 1; v.branch_taken = 1; v.branch_target = 64'h1000;
    for (int k = 0; k < 3; k++)
      run(v, $sformatf("mw%0d", k), 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b11111, 2'b0, 0, '0));
    v.dm_busy = 0;
    run(v, "mw3", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b0, 2'b11, 1, 64'h1000));
    v.branch_taken = 0;
    run(v, "mw4", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b0, 2'b0, 0, '0));
    chk("mw.stall_cnt", 64'(stall_cnt), 64'(3));
    chk("mw.flush_cnt", 64'(flush_cnt), 64'(1));

    // Reset in the middle of a wait with a redirect pending.
    v = idle; v.dm_busy = 1; v.branch_taken = 1; v.branch_target = 64'h2000;
    run(v, "rw0", 1'b0, none);
    run(v, "rw1", 1'b0, none);
    do_reset("rw");
    run(idle, "rw2", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b0, 2'b0, 0, '0));
    run(idle, "rw3", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b0, 2'b0, 0, '0));

    // ALU writer of x3 walking EX -> MEM -> WB while ID reads x3.
    do_reset("raw");
    v = idle; v.id_rs1 = 3; v.id_rs1_used = 1; v.ex_rs1 = 3; v.ex_rd = 3; v.ex_wr_en = 1;
`ifdef HAZARD_FWD_EN
    run(v, "raw0", 1'b0, none);
    v.ex_wr_en = 0; v.mem_rd = 3; v.mem_wr_en = 1; run(v, "raw1", 1'b0, none);
    v.mem_wr_en = 0; v.wb_rd = 3; v.wb_wr_en = 1; run(v, "raw2", 1'b0, none);
`else
    run(v, "raw0", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b11000, 2'b01, 0, '0));
    v.ex_wr_en = 0; v.mem_rd = 3; v.mem_wr_en = 1;
    run(v, "raw1", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b11000, 2'b01, 0, '0));
    v.mem_wr_en = 0; v.wb_rd = 3; v.wb_wr_en = 1;
    run(v, "raw2", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b11000, 2'b01, 0, '0));
`endif
    v.wb_wr_en = 0;
    run(v, "raw3", 1'b1, mk(64'hA1, 64'hA2, 0, 0, 5'b0, 2'b0, 0, '0));
    chk("raw.stall_cnt", 64'(stall_cnt), model(tab[0].i).stl[4] ? 64'(0) : 64'(m_sc));

    // Random traffic against the model; small register range to provoke matches and saturation.
    do_reset("rnd");
    for (int k = 0; k < 500; k++) begin
      v.id_rs1 = RA'($urandom_range(0, 7));       v.id_rs2 = RA'($urandom_range(0, 7));
      v.id_rs1_used = 1'($urandom);               v.id_rs2_used = 1'($urandom);
      v.ex_rs1 = RA'($urandom_range(0, 7));       v.ex_rs2 = RA'($urandom_range(0, 7));
      v.ex_rs1_rf = {$urandom, $urandom};         v.ex_rs2_rf = {$urandom, $urandom};
      v.ex_rd = RA'($urandom_range(0, 7));
      v.ex_wr_en = 1'($urandom);                  v.ex_is_load = 1'($urandom);
      v.mem_rd = RA'($urandom_range(0, 7));
      v.mem_wr_en = 1'($urandom);                 v.mem_is_load = 1'($urandom);
      v.mem_fwd_data = {$urandom, $urandom};
      v.wb_rd = RA'($urandom_range(0, 7));        v.wb_wr_en = 1'($urandom);
      v.wb_data = {$urandom, $urandom};
      v.branch_taken = ($urandom_range(0, 4) == 0);
      v.branch_target = {$urandom, $urandom};
      v.dm_busy = ($urandom_range(0, 3) == 0);
      run(v, $sformatf("rnd%0d", k), 1'b0, none);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
